// File: rtl/plab3_mem_prefetch_buffer_n.sv
// plab3_mem_prefetch_buffer_n
// Fully associative line prefetch buffer between the data cache and memory.
// Reads are served on a hit and never allocate. Prefetches allocate a line from
// memory on a miss. Invalidate-all clears every entry. One request is in flight
// at a time. Define PLAB3_MEM_PREFETCH_NEXT_LINE_EN to prefetch the next line
// automatically after every read hit.
module plab3_mem_prefetch_buffer_n #(
  parameter int p_num_entries  = 4,
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_line_nbits   = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_val,
  output logic                            req_rdy,
  input  logic [1:0]                      req_type,
  input  logic [p_addr_nbits-1:0]         req_addr,
  input  logic [p_opaque_nbits-1:0]       req_opaque,
  output logic                            resp_val,
  input  logic                            resp_rdy,
  output logic [1:0]                      resp_type,
  output logic                            resp_hit,
  output logic [p_data_nbits-1:0]         resp_data,
  output logic [p_opaque_nbits-1:0]       resp_opaque,
  output logic                            memreq_val,
  input  logic                            memreq_rdy,
  output logic [p_addr_nbits-1:0]         memreq_addr,
  input  logic                            memresp_val,
  output logic                            memresp_rdy,
  input  logic [p_line_nbits-1:0]         memresp_data,
  output logic [$clog2(p_num_entries):0]  occupancy
);

  localparam int c_idx_nbits = $clog2(p_num_entries);
  localparam int c_occ_nbits = c_idx_nbits + 1;
  localparam int c_tag_nbits = p_addr_nbits - 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_MEMREQ  = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_FILL    = 3'd4,
    ST_RESP    = 3'd5
`ifdef PLAB3_MEM_PREFETCH_NEXT_LINE_EN
    , ST_NL_LOOKUP = 3'd6
`endif
  } state_t;

  state_t                      state_r;
  logic [p_num_entries-1:0]    valid_r;
  logic [c_tag_nbits-1:0]      tag_r  [p_num_entries];
  logic [p_line_nbits-1:0]     line_r [p_num_entries];
  logic [c_idx_nbits-1:0]      rp_r;
  logic [c_occ_nbits-1:0]      occ_r;

  logic [1:0]                  type_r;
  logic [c_tag_nbits-1:0]      req_tag_r;
  logic [1:0]                  wsel_r;
  logic [p_opaque_nbits-1:0]   opaque_r;
  logic [p_line_nbits-1:0]     fill_line_r;
`ifdef PLAB3_MEM_PREFETCH_NEXT_LINE_EN
  logic                        internal_r;
`endif

  logic                        req_rdy_r;
  logic                        resp_val_r;
  logic [1:0]                  resp_type_r;
  logic                        resp_hit_r;
  logic [p_data_nbits-1:0]     resp_data_r;
  logic [p_opaque_nbits-1:0]   resp_opaque_r;
  logic                        memreq_val_r;
  logic [p_addr_nbits-1:0]     memreq_addr_r;
  logic                        memresp_rdy_r;

  logic                        hit_s;
  logic [c_idx_nbits-1:0]      hit_idx_s;
  logic [p_data_nbits-1:0]     hit_word_s;
  logic                        free_found_s;
  logic [c_idx_nbits-1:0]      free_idx_s;
  logic [c_idx_nbits-1:0]      victim_s;
  logic                        match_s;
  logic                        is_read_s;
  logic                        unused_addr_s;

  // Byte offset within a word plays no part in tag or word selection.
  assign unused_addr_s = ^req_addr[1:0];

  // Read and reserved types behave as plain reads.
  assign is_read_s = (type_r != 2'd1) && (type_r != 2'd2);

  // Parallel tag match against all valid entries and the addressed word of the hit line.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    match_s   = 1'b0;
    for (int i = 0; i < p_num_entries; i++) begin
      match_s   = valid_r[i] && (tag_r[i] == req_tag_r);
      hit_s     = hit_s | match_s;
      hit_idx_s = match_s ? c_idx_nbits'(i) : hit_idx_s;
    end
    hit_word_s = line_r[hit_idx_s][wsel_r*p_data_nbits +: p_data_nbits];
  end

  // Victim choice: lowest-index invalid entry, otherwise the round-robin pointer.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = p_num_entries - 1; i >= 0; i--) begin
      free_found_s = free_found_s | ~valid_r[i];
      free_idx_s   = valid_r[i] ? free_idx_s : c_idx_nbits'(i);
    end
    victim_s = free_found_s ? free_idx_s : rp_r;
  end

  // Control FSM, entry storage and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      valid_r       <= '0;
      rp_r          <= '0;
      occ_r         <= '0;
      type_r        <= 2'd0;
      req_tag_r     <= '0;
      wsel_r        <= 2'd0;
      opaque_r      <= '0;
      fill_line_r   <= '0;
`ifdef PLAB3_MEM_PREFETCH_NEXT_LINE_EN
      internal_r    <= 1'b0;
`endif
      req_rdy_r     <= 1'b1;
      resp_val_r    <= 1'b0;
      resp_type_r   <= 2'd0;
      resp_hit_r    <= 1'b0;
      resp_data_r   <= '0;
      resp_opaque_r <= '0;
      memreq_val_r  <= 1'b0;
      memreq_addr_r <= '0;
      memresp_rdy_r <= 1'b0;
      for (int i = 0; i < p_num_entries; i++) begin
        tag_r[i]  <= '0;
        line_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_val && req_rdy_r) begin
            type_r    <= req_type;
            req_tag_r <= req_addr[p_addr_nbits-1:4];
            wsel_r    <= req_addr[3:2];
            opaque_r  <= req_opaque;
            req_rdy_r <= 1'b0;
            state_r   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          resp_type_r   <= type_r;
          resp_opaque_r <= opaque_r;
          case (type_r)
            2'd2: begin
              valid_r     <= '0;
              rp_r        <= '0;
              occ_r       <= '0;
              resp_hit_r  <= 1'b0;
              resp_data_r <= '0;
              resp_val_r  <= 1'b1;
              state_r     <= ST_RESP;
            end
            2'd1: begin
              resp_data_r <= '0;
              resp_hit_r  <= hit_s;
              if (hit_s) begin
                resp_val_r <= 1'b1;
                state_r    <= ST_RESP;
              end else begin
                memreq_val_r  <= 1'b1;
                memreq_addr_r <= {req_tag_r, 4'h0};
                state_r       <= ST_MEMREQ;
              end
            end
            default: begin
              resp_hit_r  <= hit_s;
              resp_data_r <= hit_s ? hit_word_s : '0;
              resp_val_r  <= 1'b1;
              state_r     <= ST_RESP;
            end
          endcase
        end
        ST_MEMREQ: begin
          if (memreq_rdy) begin
            memreq_val_r  <= 1'b0;
            memresp_rdy_r <= 1'b1;
            state_r       <= ST_MEMWAIT;
          end
        end
        ST_MEMWAIT: begin
          if (memresp_val) begin
            fill_line_r   <= memresp_data;
            memresp_rdy_r <= 1'b0;
            state_r       <= ST_FILL;
          end
        end
        ST_FILL: begin
          valid_r[victim_s] <= 1'b1;
          tag_r[victim_s]   <= req_tag_r;
          line_r[victim_s]  <= fill_line_r;
          if (free_found_s) begin
            if (occ_r != c_occ_nbits'(p_num_entries)) begin
              occ_r <= occ_r + c_occ_nbits'(1);
            end
          end else begin
            rp_r <= rp_r + c_idx_nbits'(1);
          end
`ifdef PLAB3_MEM_PREFETCH_NEXT_LINE_EN
          if (internal_r) begin
            internal_r <= 1'b0;
            req_rdy_r  <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            resp_val_r <= 1'b1;
            state_r    <= ST_RESP;
          end
`else
          resp_val_r <= 1'b1;
          state_r    <= ST_RESP;
`endif
        end
        ST_RESP: begin
          if (resp_rdy) begin
            resp_val_r    <= 1'b0;
            resp_type_r   <= 2'd0;
            resp_hit_r    <= 1'b0;
            resp_data_r   <= '0;
            resp_opaque_r <= '0;
`ifdef PLAB3_MEM_PREFETCH_NEXT_LINE_EN
            if (is_read_s && resp_hit_r) begin
              req_tag_r  <= req_tag_r + c_tag_nbits'(1);
              internal_r <= 1'b1;
              state_r    <= ST_NL_LOOKUP;
            end else begin
              req_rdy_r <= 1'b1;
              state_r   <= ST_IDLE;
            end
`else
            req_rdy_r <= 1'b1;
            state_r   <= ST_IDLE;
`endif
          end
        end
`ifdef PLAB3_MEM_PREFETCH_NEXT_LINE_EN
        ST_NL_LOOKUP: begin
          if (hit_s) begin
            internal_r <= 1'b0;
            req_rdy_r  <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            memreq_val_r  <= 1'b1;
            memreq_addr_r <= {req_tag_r, 4'h0};
            state_r       <= ST_MEMREQ;
          end
        end
`endif
        default: begin
          req_rdy_r <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_rdy     = req_rdy_r;
  assign resp_val    = resp_val_r;
  assign resp_type   = resp_type_r;
  assign resp_hit    = resp_hit_r;
  assign resp_data   = resp_data_r;
  assign resp_opaque = resp_opaque_r;
  assign memreq_val  = memreq_val_r;
  assign memreq_addr = memreq_addr_r;
  assign memresp_rdy = memresp_rdy_r;
  assign occupancy   = occ_r;

endmodule

// File: tb/tb_plab3_mem_prefetch_buffer_n.sv
// Self-checking bench for plab3_mem_prefetch_buffer_n (N=4, 32-bit addr/data,
// 128-bit lines). A behavioural model of the buffer contents predicts hits,
// data, memory traffic and occupancy; the bench also plays the memory.
module tb_plab3_mem_prefetch_buffer_n;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_val, req_rdy;
  logic [1:0]   req_type;
  logic [31:0]  req_addr;
  logic [7:0]   req_opaque;
  logic         resp_val, resp_rdy;
  logic [1:0]   resp_type;
  logic         resp_hit;
  logic [31:0]  resp_data;
  logic [7:0]   resp_opaque;
  logic         memreq_val, memreq_rdy;
  logic [31:0]  memreq_addr;
  logic         memresp_val, memresp_rdy;
  logic [127:0] memresp_data;
  logic [2:0]   occupancy;

  int checks   = 0;
  int failures = 0;

  // Model state: which lines are held, in which slot, and the replacement pointer.
  bit           m_valid [4];
  logic [31:0]  m_laddr [4];
  int           m_rp;
  int           m_occ;

  always #5 clk = ~clk;

  plab3_mem_prefetch_buffer_n dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
    .req_addr(req_addr), .req_opaque(req_opaque),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type),
    .resp_hit(resp_hit), .resp_data(resp_data), .resp_opaque(resp_opaque),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_addr(memreq_addr),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_data(memresp_data),
    .occupancy(occupancy)
  );

  // Memory contents: each word depends on its line address and word position.
  function automatic logic [127:0] mem_line(input logic [31:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = la ^ (32'(k) * 32'h1111_1111);
    return l;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_rp  = 0;
    m_occ = 0;
  endfunction

  function automatic int model_find(input logic [31:0] la);
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_laddr[i] == la) return i;
    return -1;
  endfunction

  function automatic void model_fill(input logic [31:0] la);
    int v = -1;
    for (int i = 0; i < 4; i++) if (!m_valid[i] && v < 0) v = i;
    if (v < 0) begin
      v = m_rp;
      m_rp = (m_rp + 1) % 4;
    end else begin
      m_occ++;
    end
    m_valid[v] = 1'b1;
    m_laddr[v] = la;
  endfunction

  task automatic check_reset_outputs(input string p);
    chk({p, "_req_rdy"}, req_rdy, 1);
    chk({p, "_resp_val"}, resp_val, 0);
    chk({p, "_memreq_val"}, memreq_val, 0);
    chk({p, "_memresp_rdy"}, memresp_rdy, 0);
    chk({p, "_resp_type"}, resp_type, 0);
    chk({p, "_resp_hit"}, resp_hit, 0);
    chk({p, "_resp_data"}, resp_data, 0);
    chk({p, "_resp_opaque"}, resp_opaque, 0);
    chk({p, "_memreq_addr"}, memreq_addr, 0);
    chk({p, "_occupancy"}, occupancy, 0);
  endtask

  // One full transaction: predict, drive, act as memory, check response and traffic.
  task automatic txn(input logic [1:0] t, input logic [31:0] a);
    logic [31:0] la, nl, pend_addr, exp_data;
    logic [31:0] exp_mem[$];
    logic [7:0]  op;
    logic        exp_hit;
    int idx, n, memhs, nmem, mem_first, ws;
    bit done, pend, seen_resp, hs_done, memreq_rdy_now;

    la  = {a[31:4], 4'h0};
    op  = 8'($urandom);
    idx = model_find(la);
    ws  = int'(a[3:2]);
    exp_hit  = (t != 2'd2) && (idx >= 0);
    exp_data = 32'h0;
    case (t)
      2'd2: model_clear();
      2'd1: if (idx < 0) begin
        exp_mem.push_back(la);
        model_fill(la);
      end
      default: if (idx >= 0) begin
        logic [127:0] ln = mem_line(la);
        exp_data = ln[ws*32 +: 32];
`ifdef PLAB3_MEM_PREFETCH_NEXT_LINE_EN
        nl = la + 32'd16;
        if (model_find(nl) < 0) begin
          exp_mem.push_back(nl);
          model_fill(nl);
        end
`else
        nl = la;
`endif
      end
    endcase

    @(negedge clk);
    chk("req_rdy_idle", req_rdy, 1);
    req_val = 1'b1; req_type = t; req_addr = a; req_opaque = op;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0; req_type = 2'($urandom); req_addr = $urandom; req_opaque = 8'($urandom);

    n = 1; memhs = -1; nmem = 0; mem_first = -1; pend_addr = 32'h0;
    done = 1'b0; pend = 1'b0; seen_resp = 1'b0; hs_done = 1'b0;
    while (!done && n < 300) begin
      if (hs_done && req_rdy) begin
        done = 1'b1;
      end else begin
        if (!hs_done) chk("req_rdy_busy", req_rdy, 0);
        else chk("no_extra_resp", resp_val, 0);
        // memory request side
        memreq_rdy_now = 1'($urandom_range(0, 1));
        memreq_rdy = memreq_rdy_now;
        if (memreq_val) begin
          if (mem_first < 0) mem_first = n;
          if (memreq_rdy_now) begin
            if (nmem < exp_mem.size()) chk("memreq_addr", memreq_addr, exp_mem[nmem]);
            else chk("memreq_unexpected", 1, 0);
            nmem++;
            pend = 1'b1;
            pend_addr = memreq_addr;
          end
        end
        // memory response side (garbage data unless a real handshake is intended)
        memresp_val  = 1'($urandom_range(0, 1));
        memresp_data = {$urandom, $urandom, $urandom, $urandom};
        if (memresp_val && memresp_rdy) begin
          if (pend) begin
            memresp_data = mem_line(pend_addr);
            pend  = 1'b0;
            memhs = n;
          end else begin
            chk("memresp_rdy_spurious", memresp_rdy, 0);
          end
        end
        // response side
        resp_rdy = 1'b0;
        if (resp_val && !hs_done) begin
          if (!seen_resp) begin
            seen_resp = 1'b1;
            chk("resp_latency", n, (t == 2'd1 && exp_mem.size() > 0) ? memhs + 2 : 2);
          end
          chk("resp_type", resp_type, t);
          chk("resp_hit", resp_hit, exp_hit);
          chk("resp_data", resp_data, exp_data);
          chk("resp_opaque", resp_opaque, op);
          resp_rdy = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        if (resp_rdy) hs_done = 1'b1;
        @(negedge clk);
        n++;
      end
    end
    memreq_rdy = 1'b0; memresp_val = 1'b0; resp_rdy = 1'b0;
    chk("txn_done", done, 1);
    chk("memreq_count", nmem, exp_mem.size());
    if (t == 2'd1 && exp_mem.size() > 0) chk("memreq_latency", mem_first, 2);
    chk("occupancy", occupancy, m_occ);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_val = 1'b0; req_type = 2'd0; req_addr = 32'h0; req_opaque = 8'h0;
    resp_rdy = 1'b0; memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_data = 128'h0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("por");

    // read miss on an empty buffer, then prefetch and read word 2
    txn(2'd0, 32'h0000_0100);
    txn(2'd1, 32'h0000_0100);
    txn(2'd0, 32'h0000_0108);

    // capacity and replacement: fifth line evicts the first
    txn(2'd2, 32'h0);
    for (int k = 0; k < 5; k++) txn(2'd1, 32'(k) * 32'h10);
    txn(2'd0, 32'h0000_0000);
    txn(2'd0, 32'h0000_0014);

    // duplicate prefetch hits without memory traffic
    txn(2'd2, 32'h0);
    txn(2'd1, 32'h0000_0200);
    txn(2'd1, 32'h0000_0204);

    // invalidate clears everything; allocation restarts at entry 0
    txn(2'd1, 32'h0000_0500);
    txn(2'd1, 32'h0000_0510);
    txn(2'd2, 32'h0);
    txn(2'd0, 32'h0000_0500);
    txn(2'd0, 32'h0000_0514);
    txn(2'd0, 32'h0000_0200);
    for (int k = 0; k < 5; k++) txn(2'd1, 32'h0000_0600 + 32'(k) * 32'h10);
    txn(2'd0, 32'h0000_0600);
    txn(2'd0, 32'h0000_0610);

    // top-of-memory line: next-line address wraps to 0; reserved type acts as read
    txn(2'd2, 32'h0);
    txn(2'd1, 32'hFFFF_FFF0);
    txn(2'd0, 32'hFFFF_FFF8);
    txn(2'd3, 32'hFFFF_FFF4);

    // reset in the middle of a refill, then a late memory response is ignored
    @(negedge clk);
    req_val = 1'b1; req_type = 2'd1; req_addr = 32'h0000_0300; req_opaque = 8'h5a;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    for (int k = 0; k < 20 && !memresp_rdy; k++) begin
      memreq_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    memreq_rdy = 1'b0;
    chk("mid_memresp_rdy", memresp_rdy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    check_reset_outputs("mid");
    memresp_val = 1'b1; memresp_data = mem_line(32'h0000_0300);
    @(posedge clk);
    @(negedge clk);
    chk("late_memresp_rdy", memresp_rdy, 0);
    chk("late_occupancy", occupancy, 0);
    chk("late_req_rdy", req_rdy, 1);
    memresp_val = 1'b0;
    txn(2'd0, 32'h0000_0300);

    // randomized mix over a small pool of lines so hits and evictions are common
    for (int r = 0; r < 80; r++) begin
      int sel;
      logic [1:0] t;
      logic [31:0] a;
      sel = $urandom_range(0, 19);
      t = (sel == 0) ? 2'd2 : (sel == 1) ? 2'd3 : (sel < 10) ? 2'd1 : 2'd0;
      a = 32'h0000_1000 + 32'($urandom_range(0, 7)) * 32'h10 + 32'($urandom_range(0, 15));
      txn(t, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
